// File: rtl/stack_pkg.sv
// Shared constants, op encoding and FSM state type for the stack request front end.
// Latency: none (declarations only).
// Backpressure: n/a.
package stack_pkg;

  localparam int STK_DW    = 12;
  localparam int STK_DEPTH = 8;
  localparam int STK_CW    = 4;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/stack_req_ctrl_if.sv
// Request/response channel bundle between a command source and stack_req_ctrl.
// Latency: none (wiring only).
// Backpressure: req_ready stalls the source, resp_ready stalls the controller.
//   master : drives req_valid/req_op/req_data/resp_ready (command source)
//   slave  : drives req_ready/resp_valid/resp_data (stack_req_ctrl)
interface stack_req_ctrl_if #(
  parameter int DW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/stack_occ_cnt.sv
// Occupancy counter for the stack: up on push, down on pop, never wraps.
// Latency: count updates on the edge after an inc/dec request.
// Backpressure: none; inc at full and dec at empty are ignored.
//   i_inc/i_dec : one-cycle increment / decrement requests
//   o_count     : current occupancy, o_empty : count == 0, o_at_full : count == DEPTH
module stack_occ_cnt #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_at_full
);

  logic [CW-1:0] r_count;
  logic          w_empty;
  logic          w_at_full;

  assign w_empty   = (r_count == '0);
  assign w_at_full = (r_count == CW'(DEPTH));

  // Simultaneous inc and dec cancel; the guards keep the count inside 0..DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_at_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && !w_empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_empty   = w_empty;
  assign o_at_full = w_at_full;

endmodule

// File: rtl/stack_req_ctrl.sv
// Request front end for the stack: turns push/pop requests into stack enables, returns popped data.
// Latency: push accept->stk_push 1 cycle; pop accept->resp_valid 2+RD_LAT cycles.
// Backpressure: req_ready low outside IDLE and for illegal ops; resp held until resp_ready.
//   clk, reset          : clock, async active-low reset (reset the stack together with this block)
//   bus (slave)         : req_valid/req_ready/req_op/req_data, resp_valid/resp_ready/resp_data
//   stk_push/stk_pop    : one-cycle enables to the stack, stk_pushdata registered push data
//   stk_popdata/stk_full: data and full flag from the stack
//   count/empty         : occupancy
//   err/err_sticky      : only with STACK_REQ_ERR_EN defined (illegal ops dropped instead of stalled)
module stack_req_ctrl
  import stack_pkg::*;
#(
  parameter int DW     = STK_DW,
  parameter int DEPTH  = STK_DEPTH,
  parameter int CW     = STK_CW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  stack_req_ctrl_if.slave bus,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_pushdata,
  input  logic [DW-1:0] stk_popdata,
  input  logic          stk_full,
`ifdef STACK_REQ_ERR_EN
  output logic          err,
  output logic          err_sticky,
`endif
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_wait_cnt;
  logic [DW-1:0] r_pushdata;
  logic [DW-1:0] r_resp_data;
  logic          w_req_ready;
  logic          w_legal;
  logic          w_accept;
  logic          w_wait_last;
  logic          w_empty;
  logic          w_at_full;

  stack_occ_cnt #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_occ (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (r_state == PUSH),
    .i_dec     (r_state == POP),
    .o_count   (count),
    .o_empty   (w_empty),
    .o_at_full (w_at_full)
  );

  // stk_full with count below DEPTH means the stack and this block disagree;
  // block the push anyway rather than trust either side.
  assign w_legal     = (bus.req_op == OP_PUSH) ? (!w_at_full && !stk_full) : !w_empty;
  assign w_wait_last = (r_state == WAIT) && (r_wait_cnt == 2'd0);
  assign w_accept    = bus.req_valid && w_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by reset so the channel never looks ready while the block is held in reset.
`ifdef STACK_REQ_ERR_EN
        w_req_ready = reset;
`else
        w_req_ready = reset && w_legal;
`endif
        // Illegal ops that get accepted (error build) stay in IDLE and are dropped.
        if (bus.req_valid && w_req_ready && w_legal) begin
          w_state_nxt = (bus.req_op == OP_PUSH) ? PUSH : POP;
        end
      end
      PUSH:    w_state_nxt = IDLE;
      POP:     w_state_nxt = WAIT;
      WAIT:    if (w_wait_last) w_state_nxt = RESP;
      RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // WAIT dwell counter, loaded as the pop pulse goes out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == POP) begin
      r_wait_cnt <= WAIT_INIT;
    end else if ((r_state == WAIT) && (r_wait_cnt != 2'd0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pushdata <= '0;
    end else if ((r_state == IDLE) && w_accept && w_legal && (bus.req_op == OP_PUSH)) begin
      r_pushdata <= bus.req_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_data <= '0;
    end else if (w_wait_last) begin
      r_resp_data <= stk_popdata;
    end
  end

`ifdef STACK_REQ_ERR_EN
  logic r_err;
  logic r_err_sticky;
  logic w_drop;

  assign w_drop = (r_state == IDLE) && w_accept && !w_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err        <= w_drop;
      r_err_sticky <= r_err_sticky || w_drop;
    end
  end

  assign err        = r_err;
  assign err_sticky = r_err_sticky;
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_data  = r_resp_data;
  assign stk_push       = (r_state == PUSH);
  assign stk_pop        = (r_state == POP);
  assign stk_pushdata   = r_pushdata;
  assign empty          = w_empty;

endmodule
